vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_pkg.sv | 16 +
 rtl/vram_clr_seq.sv | 63 ++++++
 rtl/vram_arbiter.sv | 162 ++++++++++++++++
 tb/tb_vram_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared defaults and RAM slot-owner encoding for the text-mode VRAM arbiter.
package vram_pkg;

    localparam int unsigned VRAM_DEPTH_DEF = 4800;
    localparam int unsigned ADDR_W_DEF     = 13;
    localparam int unsigned DATA_W_DEF     = 16;

    typedef enum logic [2:0] {
        SLOT_NONE,
        SLOT_VGA,
        SLOT_CPU_WR,
        SLOT_CPU_RD,
        SLOT_CLR
    } slot_e;

endpackage

// File: rtl/vram_clr_seq.sv
// Fill sequencer: walks every VRAM address once, writing the latched fill word
// in whichever slots the arbiter hands it.
module vram_clr_seq
    import vram_pkg::*;
#(
    parameter int unsigned VRAM_DEPTH = VRAM_DEPTH_DEF,
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [DATA_W-1:0] value_i,
    input  logic              gnt_i,
    output logic              req_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(VRAM_DEPTH - 1);

    logic              busy_q;
    logic              last_q;
    logic              done_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [DATA_W-1:0] value_q;

    // last_q marks the cycle the final write is on the RAM port; done follows it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q  <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            value_q <= '0;
        end else begin
            last_q <= 1'b0;
            done_q <= last_q;
            if (busy_q) begin
                if (gnt_i) begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_ADDR) begin
                        busy_q <= 1'b0;
                        last_q <= 1'b1;
                    end
                end
            end else if (start_i) begin
                busy_q  <= 1'b1;
                cnt_q   <= '0;
                value_q <= value_i;
            end
        end
    end

    assign req_o  = busy_q;
    assign addr_o = cnt_q;
    assign data_o = value_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: one RAM slot per clock, VGA > CPU > clear, with
// owner tags following each access down the 2-cycle read pipeline.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int unsigned VRAM_DEPTH = VRAM_DEPTH_DEF,
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vga_rdn,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_data,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_value,
    output logic              clr_busy,
    output logic              clr_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(VRAM_DEPTH);

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < DEPTH_C;
    endfunction

    logic              vga_rdn_q;
    slot_e             slot_d;
    slot_e             slot1_q;
    slot_e             slot2_q;
    logic              oor1_q;
    logic              oor2_q;
    logic              cpu_busy_q;
    logic              cpu_ack_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] vga_data_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic              ram_we_q;
    logic [DATA_W-1:0] ram_din_q;

    logic              vga_edge;
    logic              cpu_gnt;
    logic              clr_req;
    logic              clr_gnt;
    logic [ADDR_W-1:0] clr_addr;
    logic [DATA_W-1:0] clr_data;

    vram_clr_seq #(
        .VRAM_DEPTH(VRAM_DEPTH),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W)
    ) u_clr (
        .clk_i  (clk),
        .rst_ni (rst),
        .start_i(clr_start),
        .value_i(clr_value),
        .gnt_i  (clr_gnt),
        .req_o  (clr_req),
        .addr_o (clr_addr),
        .data_o (clr_data),
        .busy_o (clr_busy),
        .done_o (clr_done)
    );

    // cpu_busy_q stays set through the ack cycle so a held cpu_req cannot re-issue.
    always_comb begin
        vga_edge = vga_rdn_q & ~vga_rdn;
        cpu_gnt  = cpu_req & ~cpu_busy_q & ~vga_edge;
        slot_d   = SLOT_NONE;
        if (vga_edge) begin
            slot_d = SLOT_VGA;
        end else if (cpu_gnt) begin
            slot_d = cpu_we ? SLOT_CPU_WR : SLOT_CPU_RD;
        end else if (clr_req) begin
            slot_d = SLOT_CLR;
        end
        clr_gnt = (slot_d == SLOT_CLR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vga_rdn_q   <= 1'b1;
            slot1_q     <= SLOT_NONE;
            slot2_q     <= SLOT_NONE;
            oor1_q      <= 1'b0;
            oor2_q      <= 1'b0;
            cpu_busy_q  <= 1'b0;
            cpu_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            vga_data_q  <= '0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_din_q   <= '0;
        end else begin
            vga_rdn_q <= vga_rdn;
            slot1_q   <= slot_d;
            slot2_q   <= slot1_q;
            oor2_q    <= oor1_q;
            ram_we_q  <= 1'b0;
            cpu_ack_q <= 1'b0;
            oor1_q    <= 1'b0;
            if (cpu_ack_q) begin
                cpu_busy_q <= 1'b0;
            end

            case (slot_d)
                SLOT_VGA: begin
                    ram_addr_q <= vga_addr;
                    oor1_q     <= ~in_range(vga_addr);
                end
                SLOT_CPU_WR: begin
                    ram_addr_q <= cpu_addr;
                    ram_din_q  <= cpu_wdata;
                    ram_we_q   <= in_range(cpu_addr);
                    cpu_ack_q  <= 1'b1;
                    cpu_busy_q <= 1'b1;
                end
                SLOT_CPU_RD: begin
                    ram_addr_q <= cpu_addr;
                    oor1_q     <= ~in_range(cpu_addr);
                    cpu_busy_q <= 1'b1;
                end
                SLOT_CLR: begin
                    ram_addr_q <= clr_addr;
                    ram_din_q  <= clr_data;
                    ram_we_q   <= 1'b1;
                end
                default: ;
            endcase

            // Read data returns one cycle after the address slot; capture by tag.
            case (slot2_q)
                SLOT_VGA: begin
                    vga_data_q <= oor2_q ? '0 : ram_dout;
                end
                SLOT_CPU_RD: begin
                    cpu_rdata_q <= oor2_q ? '0 : ram_dout;
                    cpu_ack_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign vga_data  = vga_data_q;
    assign cpu_ack   = cpu_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign ram_addr  = ram_addr_q;
    assign ram_we    = ram_we_q;
    assign ram_din   = ram_din_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural synchronous VRAM attached.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        vga_rdn = 1'b1;
    logic [12:0] vga_addr = '0;
    logic [15:0] vga_data;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [12:0] cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;
    logic        clr_start = 1'b0;
    logic [15:0] clr_value = '0;
    logic        clr_busy;
    logic        clr_done;
    logic [12:0] ram_addr;
    logic        ram_we;
    logic [15:0] ram_din;
    logic [15:0] ram_dout;

    logic        pl_en = 1'b0;
    logic [12:0] pl_addr = '0;
    logic [15:0] pl_data = '0;
    logic [15:0] mem [0:4799];
    bit          written [0:4799];
    bit          stop_flag;

    int checks = 0;
    int failures = 0;

    initial forever #5 clk = ~clk;

    vram_arbiter #(
        .VRAM_DEPTH(4800),
        .ADDR_W    (13),
        .DATA_W    (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .vga_rdn  (vga_rdn),
        .vga_addr (vga_addr),
        .vga_data (vga_data),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_ack  (cpu_ack),
        .cpu_rdata(cpu_rdata),
        .clr_start(clr_start),
        .clr_value(clr_value),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    // Out-of-range reads return a non-zero pattern so zeroing by the DUT is visible.
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (ram_we && ram_addr < 13'd4800) mem[ram_addr] <= ram_din;
        ram_dout <= (ram_addr < 13'd4800) ? mem[ram_addr] : 16'hDEAD;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [12:0] a, input logic [15:0] d);
        pl_addr = a; pl_data = d; pl_en = 1'b1;
        tick();
        pl_en = 1'b0;
    endtask

    // Holds cpu_req through the ack cycle, then watches for stray re-issues.
    task automatic cpu_op(input logic we, input logic [12:0] a, input logic [15:0] wd,
                          output int lat, output logic [15:0] rd, output int extra,
                          output logic we_seen);
        lat = -1; extra = 0; we_seen = 1'b0; rd = '0;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            tick();
            if (ram_we) we_seen = 1'b1;
            if (cpu_ack) begin lat = i; rd = cpu_rdata; end
        end
        tick();
        if (cpu_ack) extra++;
        if (ram_we) we_seen = 1'b1;
        cpu_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (cpu_ack) extra++;
            if (ram_we) we_seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) tick();
        checks++; if (vga_data !== 16'h0) begin failures++; $display("FAIL rst_vga_data: got %h expected 0000", vga_data); end
        checks++; if (cpu_rdata !== 16'h0) begin failures++; $display("FAIL rst_cpu_rdata: got %h expected 0000", cpu_rdata); end
        checks++; if (ram_addr !== 13'h0) begin failures++; $display("FAIL rst_ram_addr: got %h expected 0000", ram_addr); end
        checks++; if (ram_din !== 16'h0) begin failures++; $display("FAIL rst_ram_din: got %h expected 0000", ram_din); end
        checks++; if ({cpu_ack, ram_we, clr_busy, clr_done} !== 4'b0) begin failures++; $display("FAIL rst_flags: got %b expected 0000", {cpu_ack, ram_we, clr_busy, clr_done}); end
        rst = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_vga_fetch();
        preload(13'h0010, 16'h1A41);
        tick();
        vga_addr = 13'h0010; vga_rdn = 1'b0;
        tick();
        checks++; if (ram_addr !== 13'h0010 || ram_we !== 1'b0) begin failures++; $display("FAIL vga_addr_n1: got addr %h we %b expected 0010 0", ram_addr, ram_we); end
        tick();
        checks++; if (vga_data !== 16'h0000) begin failures++; $display("FAIL vga_data_n2: got %h expected 0000", vga_data); end
        tick();
        checks++; if (vga_data !== 16'h1A41) begin failures++; $display("FAIL vga_data_n3: got %h expected 1a41", vga_data); end
        tick();
        vga_rdn = 1'b1;
        repeat (4) tick();
        checks++; if (vga_data !== 16'h1A41) begin failures++; $display("FAIL vga_data_hold: got %h expected 1a41", vga_data); end
    endtask

    task automatic test_vga_oor();
        vga_addr = 13'd4800; vga_rdn = 1'b0;
        tick();
        checks++; if (ram_addr !== 13'h12C0) begin failures++; $display("FAIL vga_oor_addr: got %h expected 12c0", ram_addr); end
        tick();
        tick();
        checks++; if (vga_data !== 16'h0000) begin failures++; $display("FAIL vga_oor_data: got %h expected 0000", vga_data); end
        tick();
        vga_rdn = 1'b1;
        tick();
    endtask

    task automatic test_cpu_vs_vga();
        int acks;
        int lat, extra;
        logic [15:0] rd;
        logic ws;
        preload(13'h0020, 16'h2B52);
        tick();
        vga_addr = 13'h0020; vga_rdn = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0050; cpu_wdata = 16'hBEEF;
        tick();
        checks++; if (ram_addr !== 13'h0020 || ram_we !== 1'b0 || cpu_ack !== 1'b0) begin failures++; $display("FAIL coll_vga_first: got addr %h we %b ack %b expected 0020 0 0", ram_addr, ram_we, cpu_ack); end
        tick();
        checks++; if (ram_addr !== 13'h0050 || ram_we !== 1'b1 || ram_din !== 16'hBEEF) begin failures++; $display("FAIL coll_cpu_wr: got addr %h we %b din %h expected 0050 1 beef", ram_addr, ram_we, ram_din); end
        checks++; if (cpu_ack !== 1'b1) begin failures++; $display("FAIL coll_cpu_ack: got %b expected 1", cpu_ack); end
        tick();
        checks++; if (cpu_ack !== 1'b0 || ram_we !== 1'b0) begin failures++; $display("FAIL coll_no_reissue: got ack %b we %b expected 0 0", cpu_ack, ram_we); end
        checks++; if (vga_data !== 16'h2B52) begin failures++; $display("FAIL coll_vga_data: got %h expected 2b52", vga_data); end
        cpu_req = 1'b0;
        acks = 0;
        repeat (4) begin tick(); if (cpu_ack) acks++; end
        checks++; if (acks != 0) begin failures++; $display("FAIL coll_single_ack: got %0d extra acks expected 0", acks); end
        vga_rdn = 1'b1;
        tick();
        cpu_op(1'b0, 13'h0050, 16'h0, lat, rd, extra, ws);
        checks++; if (lat != 3) begin failures++; $display("FAIL rd_latency: got %0d expected 3", lat); end
        checks++; if (rd !== 16'hBEEF) begin failures++; $display("FAIL rd_data: got %h expected beef", rd); end
        checks++; if (extra != 0) begin failures++; $display("FAIL rd_extra_ack: got %0d expected 0", extra); end
    endtask

    task automatic test_cpu_oor();
        int lat, extra;
        logic [15:0] rd;
        logic ws;
        cpu_op(1'b0, 13'd4800, 16'h0, lat, rd, extra, ws);
        checks++; if (lat != 3 || extra != 0) begin failures++; $display("FAIL oor_rd_ack: got lat %0d extra %0d expected 3 0", lat, extra); end
        checks++; if (rd !== 16'h0000) begin failures++; $display("FAIL oor_rd_data: got %h expected 0000", rd); end
        checks++; if (ws !== 1'b0) begin failures++; $display("FAIL oor_rd_we: got %b expected 0", ws); end
        cpu_op(1'b1, 13'd4800, 16'hCAFE, lat, rd, extra, ws);
        checks++; if (lat != 1 || extra != 0) begin failures++; $display("FAIL oor_wr_ack: got lat %0d extra %0d expected 1 0", lat, extra); end
        checks++; if (ws !== 1'b0) begin failures++; $display("FAIL oor_wr_we: got %b expected 0", ws); end
    endtask

    task automatic test_clear_idle();
        int wr = 0, bad = 0, first = -1, last = -1, done_at = -1, dones = 0, mism = 0;
        logic [12:0] exp_a = '0;
        clr_value = 16'h0720; clr_start = 1'b1;
        tick();
        clr_start = 1'b0; clr_value = 16'h0;
        checks++; if (clr_busy !== 1'b1) begin failures++; $display("FAIL clr_busy_set: got %b expected 1", clr_busy); end
        for (int i = 2; i <= 6000 && !(done_at > 0 && i > done_at + 4); i++) begin
            tick();
            if (i == 100) begin clr_start = 1'b1; clr_value = 16'h1234; end
            if (i == 101) begin clr_start = 1'b0; clr_value = 16'h0; end
            if (ram_we) begin
                if (ram_addr !== exp_a || ram_din !== 16'h0720) bad++;
                exp_a = exp_a + 13'd1;
                wr++;
                if (first < 0) first = i;
                last = i;
            end
            if (clr_done) begin dones++; done_at = i; end
        end
        checks++; if (wr != 4800) begin failures++; $display("FAIL clr_write_count: got %0d expected 4800", wr); end
        checks++; if (bad != 0) begin failures++; $display("FAIL clr_addr_data: got %0d bad writes expected 0", bad); end
        checks++; if (first != 2 || last != 4801) begin failures++; $display("FAIL clr_consecutive: got first %0d last %0d expected 2 4801", first, last); end
        checks++; if (dones != 1 || done_at != 4802) begin failures++; $display("FAIL clr_done_pulse: got %0d pulses at %0d expected 1 at 4802", dones, done_at); end
        checks++; if (clr_busy !== 1'b0) begin failures++; $display("FAIL clr_busy_end: got %b expected 0", clr_busy); end
        for (int i = 0; i < 4800; i++) if (mem[i] !== 16'h0720) mism++;
        checks++; if (mism != 0) begin failures++; $display("FAIL clr_mem_fill: got %0d wrong words expected 0", mism); end
    endtask

    task automatic test_clear_traffic();
        int dones = 0, clr_wr = 0, uniq = 0, mism = 0;
        for (int i = 0; i < 4800; i++) written[i] = 1'b0;
        stop_flag = 1'b0;
        clr_value = 16'h5555; clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        fork
            begin
                bit seen;
                seen = 1'b0;
                for (int i = 0; i < 20000 && !seen; i++) begin
                    tick();
                    if (ram_we && ram_din === 16'h5555) begin
                        clr_wr++;
                        if (ram_addr < 13'd4800) begin
                            if (!written[ram_addr]) uniq++;
                            written[ram_addr] = 1'b1;
                        end
                    end
                    if (clr_done) begin dones++; seen = 1'b1; end
                end
                repeat (6) begin
                    tick();
                    if (clr_done) dones++;
                    if (ram_we && ram_din === 16'h5555) clr_wr++;
                end
                stop_flag = 1'b1;
            end
            begin
                logic [12:0] a;
                logic [15:0] exp_d, prev_d;
                prev_d = vga_data;
                for (int k = 0; k < 5000 && !stop_flag; k++) begin
                    a = 13'((k * 97 + 13) % 4800);
                    vga_addr = a; vga_rdn = 1'b0;
                    tick();
                    checks++; if (ram_addr !== a) begin failures++; $display("FAIL busy_vga_addr: got %h expected %h", ram_addr, a); end
                    exp_d = mem[a];
                    tick();
                    checks++; if (vga_data !== prev_d) begin failures++; $display("FAIL busy_vga_early: got %h expected %h", vga_data, prev_d); end
                    tick();
                    checks++; if (vga_data !== exp_d) begin failures++; $display("FAIL busy_vga_data: got %h expected %h", vga_data, exp_d); end
                    prev_d = exp_d;
                    tick();
                    vga_rdn = 1'b1;
                    tick();
                end
            end
            begin
                int lat, extra;
                logic [15:0] rd;
                logic ws;
                for (int k = 0; k < 300; k++) begin
                    cpu_op(1'b1, 13'(4000 + k), 16'(16'hA000 + k), lat, rd, extra, ws);
                    checks++; if (lat < 1 || lat > 2 || extra != 0) begin failures++; $display("FAIL busy_cpu_wr: got lat %0d extra %0d expected 1..2 0", lat, extra); end
                end
                cpu_op(1'b1, 13'd3, 16'hA002, lat, rd, extra, ws);
                checks++; if (lat < 1 || lat > 2 || extra != 0) begin failures++; $display("FAIL busy_cpu_wr3: got lat %0d extra %0d expected 1..2 0", lat, extra); end
                cpu_op(1'b0, 13'd3, 16'h0, lat, rd, extra, ws);
                checks++; if (lat < 3 || lat > 4 || rd !== 16'hA002) begin failures++; $display("FAIL busy_cpu_rd3: got lat %0d data %h expected 3..4 a002", lat, rd); end
            end
        join
        vga_rdn = 1'b1;
        checks++; if (dones != 1) begin failures++; $display("FAIL busy_clr_done: got %0d pulses expected 1", dones); end
        checks++; if (uniq != 4800 || clr_wr != 4800) begin failures++; $display("FAIL busy_clr_cover: got %0d addrs %0d writes expected 4800 4800", uniq, clr_wr); end
        for (int i = 4000; i < 4300; i++) if (mem[i] !== 16'h5555) mism++;
        checks++; if (mism != 0) begin failures++; $display("FAIL busy_clr_overwrite: got %0d cpu words kept expected 0", mism); end
        checks++; if (mem[3] !== 16'hA002) begin failures++; $display("FAIL busy_cpu_after_clr: got %h expected a002", mem[3]); end
    endtask

    task automatic test_reset_mid();
        int acks = 0, dones = 0, busy = 0, wes = 0;
        clr_value = 16'h1111; clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'd3;
        tick();
        tick();
        #2 rst = 1'b0;
        #1;
        checks++; if (vga_data !== 16'h0 || cpu_rdata !== 16'h0) begin failures++; $display("FAIL midrst_data: got vga %h cpu %h expected 0000 0000", vga_data, cpu_rdata); end
        checks++; if (ram_addr !== 13'h0 || ram_din !== 16'h0) begin failures++; $display("FAIL midrst_ram: got addr %h din %h expected 0000 0000", ram_addr, ram_din); end
        checks++; if ({cpu_ack, ram_we, clr_busy, clr_done} !== 4'b0) begin failures++; $display("FAIL midrst_flags: got %b expected 0000", {cpu_ack, ram_we, clr_busy, clr_done}); end
        cpu_req = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        repeat (10) begin
            tick();
            if (cpu_ack) acks++;
            if (clr_done) dones++;
            if (clr_busy) busy++;
            if (ram_we) wes++;
        end
        checks++; if (acks != 0) begin failures++; $display("FAIL midrst_ack: got %0d expected 0", acks); end
        checks++; if (dones != 0 || busy != 0) begin failures++; $display("FAIL midrst_clear: got done %0d busy %0d expected 0 0", dones, busy); end
        checks++; if (wes != 0) begin failures++; $display("FAIL midrst_we: got %0d expected 0", wes); end
    endtask

    initial begin
        test_reset();
        test_vga_fetch();
        test_vga_oor();
        test_cpu_vs_vga();
        test_cpu_oor();
        test_clear_idle();
        test_clear_traffic();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
